// File: rtl/npu_feeder_pkg.sv
// Shared types and helpers for the TinyNPU skewed operand feeder.
package npu_feeder_pkg;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  // Bit offset of a lane inside a packed SIZE*width bus.
  function automatic int lane_slice(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/npu_lane_fifo.sv
// Single-lane circular-buffer FIFO; a push into a full lane is accepted when
// the same cycle also pops, and a pop of an empty lane is ignored.
module npu_lane_fifo #(
  parameter int NBITS = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [NBITS-1:0] din,
  output logic [NBITS-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [NBITS-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/npu_skew_feeder.sv
// Per-lane x/w FIFOs popped in lockstep for a programmed stream length, with
// lane i delayed i extra cycles so the array edge sees staggered operands.
module npu_skew_feeder
  import npu_feeder_pkg::*;
#(
  parameter int SIZE  = 4,
  parameter int NBITS = 8,
  parameter int DEPTH = 4,
  parameter int LBITS = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NBITS-1:0]        x_in,
  input  logic                    x_load_val,
  input  logic [$clog2(SIZE)-1:0] x_load_sel,
  input  logic [NBITS-1:0]        w_in,
  input  logic                    w_load_val,
  input  logic [$clog2(SIZE)-1:0] w_load_sel,
  input  logic                    start,
  input  logic [LBITS-1:0]        stream_len,
  input  logic                    err_clr,
  output logic                    busy,
  output logic                    done,
  output logic [SIZE*NBITS-1:0]   x_out,
  output logic [SIZE-1:0]         x_out_val,
  output logic [SIZE*NBITS-1:0]   w_out,
  output logic [SIZE-1:0]         w_out_val,
  output logic [SIZE-1:0]         x_full,
  output logic [SIZE-1:0]         w_full,
  output logic [SIZE-1:0]         x_empty,
  output logic [SIZE-1:0]         w_empty,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int SZB = $clog2(SIZE + 1);
  localparam int CW  = (LBITS > SZB) ? LBITS : SZB;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             pop_all, ov_set, un_set;
  logic [SIZE-1:0]  x_push, w_push;
  logic [NBITS-1:0] x_dout [SIZE];
  logic [NBITS-1:0] w_dout [SIZE];

  assign pop_all = (state == STREAM);
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

  // A pop frees the slot a full-lane push lands in, so overflow is only
  // possible while not streaming.
  assign ov_set = (|((x_push & x_full) | (w_push & w_full))) & ~pop_all;
  assign un_set = pop_all & (|(x_empty | w_empty));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      overflow  <= (overflow & ~err_clr) | ov_set;
      underflow <= (underflow & ~err_clr) | un_set;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          cnt_nx   = CW'(stream_len);
          state_nx = (stream_len != '0) ? STREAM : DONE;
        end
      end
      STREAM: begin
        if (cnt == CW'(1)) begin
          state_nx = DRAIN;
          cnt_nx   = CW'(SIZE);
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      DRAIN: begin
        if (cnt == CW'(1)) state_nx = DONE;
        else               cnt_nx   = cnt - 1'b1;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    logic [NBITS:0] x_skew [i+1];
    logic [NBITS:0] w_skew [i+1];

    assign x_push[i] = x_load_val && (int'(x_load_sel) == i);
    assign w_push[i] = w_load_val && (int'(w_load_sel) == i);

    npu_lane_fifo #(.NBITS(NBITS), .DEPTH(DEPTH)) u_x_fifo (
      .clk(clk), .rst(rst), .push(x_push[i]), .pop(pop_all), .din(x_in),
      .dout(x_dout[i]), .full(x_full[i]), .empty(x_empty[i])
    );

    npu_lane_fifo #(.NBITS(NBITS), .DEPTH(DEPTH)) u_w_fifo (
      .clk(clk), .rst(rst), .push(w_push[i]), .pop(pop_all), .din(w_in),
      .dout(w_dout[i]), .full(w_full[i]), .empty(w_empty[i])
    );

    // Stage 0 captures {val, data} of the pop; stages 1..i add the lane skew.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k <= i; k++) begin
          x_skew[k] <= '0;
          w_skew[k] <= '0;
        end
      end else begin
        x_skew[0] <= pop_all ? {~x_empty[i], x_dout[i] & {NBITS{~x_empty[i]}}} : '0;
        w_skew[0] <= pop_all ? {~w_empty[i], w_dout[i] & {NBITS{~w_empty[i]}}} : '0;
        for (int k = 1; k <= i; k++) begin
          x_skew[k] <= x_skew[k-1];
          w_skew[k] <= w_skew[k-1];
        end
      end
    end

    assign x_out[lane_slice(i, NBITS) +: NBITS] = x_skew[i][NBITS-1:0];
    assign w_out[lane_slice(i, NBITS) +: NBITS] = w_skew[i][NBITS-1:0];
    assign x_out_val[i] = x_skew[i][NBITS];
    assign w_out_val[i] = w_skew[i][NBITS];
  end

endmodule

// File: tb/tb_npu_skew_feeder.sv
// Scoreboard bench for npu_skew_feeder: directed loads/streams push expected
// {cycle, data} per lane; a negedge monitor pops and compares outputs.
module tb_npu_skew_feeder;

  localparam int SIZE  = 4;
  localparam int NBITS = 8;
  localparam int DEPTH = 4;
  localparam int LBITS = $clog2(DEPTH + 1);

  logic                  clk, rst;
  logic [NBITS-1:0]      x_in, w_in;
  logic                  x_load_val, w_load_val;
  logic [1:0]            x_load_sel, w_load_sel;
  logic                  start, err_clr;
  logic [LBITS-1:0]      stream_len;
  logic                  busy, done, overflow, underflow;
  logic [SIZE*NBITS-1:0] x_out, w_out;
  logic [SIZE-1:0]       x_out_val, w_out_val, x_full, w_full, x_empty, w_empty;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int t;
  int xq [SIZE][$];
  int wq [SIZE][$];
  int dq [$];

  npu_skew_feeder #(.SIZE(SIZE), .NBITS(NBITS), .DEPTH(DEPTH), .LBITS(LBITS)) dut (
    .clk(clk), .rst(rst),
    .x_in(x_in), .x_load_val(x_load_val), .x_load_sel(x_load_sel),
    .w_in(w_in), .w_load_val(w_load_val), .w_load_sel(w_load_sel),
    .start(start), .stream_len(stream_len), .err_clr(err_clr),
    .busy(busy), .done(done),
    .x_out(x_out), .x_out_val(x_out_val), .w_out(w_out), .w_out_val(w_out_val),
    .x_full(x_full), .w_full(w_full), .x_empty(x_empty), .w_empty(w_empty),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic ex(input bit is_w, input int lane, input int c, input int d);
    if (is_w) wq[lane].push_back(c * 256 + (d & 255));
    else      xq[lane].push_back(c * 256 + (d & 255));
  endtask

  task automatic mon_lane(input bit is_w, input int i, input logic v, input logic [7:0] d);
    int    e;
    string nm;
    nm = $sformatf("%s%0d", is_w ? "w" : "x", i);
    if (v) begin
      if ((is_w ? wq[i].size() : xq[i].size()) == 0) begin
        tests++;
        fails++;
        $display("FAIL %s_unexpected_valid: got data 0x%0h expected no output (cycle %0d)", nm, d, cyc);
      end else begin
        e = is_w ? wq[i].pop_front() : xq[i].pop_front();
        chk({nm, "_data"}, 32'(d), 32'(e % 256));
        chk({nm, "_cycle"}, 32'(cyc), 32'(e / 256));
      end
    end else begin
      chk({nm, "_idle_data"}, 32'(d), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < SIZE; i++) begin
      mon_lane(1'b0, i, x_out_val[i], x_out[i*NBITS +: NBITS]);
      mon_lane(1'b1, i, w_out_val[i], w_out[i*NBITS +: NBITS]);
    end
    if (done) begin
      if (dq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL done_unexpected: got done=1 expected 0 (cycle %0d)", cyc);
      end else begin
        chk("done_cycle", 32'(cyc), 32'(dq.pop_front()));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input logic xv, input int xs, input int xd,
                      input logic wv, input int ws, input int wd);
    x_load_val = xv; x_load_sel = 2'(xs); x_in = 8'(xd);
    w_load_val = wv; w_load_sel = 2'(ws); w_in = 8'(wd);
    step(1);
    x_load_val = 1'b0;
    w_load_val = 1'b0;
  endtask

  task automatic do_start(input int len, output int ts);
    start = 1'b1;
    stream_len = LBITS'(len);
    ts = cyc;
    step(1);
    start = 1'b0;
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    x_in = '0; w_in = '0; x_load_val = 0; w_load_val = 0;
    x_load_sel = '0; w_load_sel = '0; start = 0; stream_len = '0; err_clr = 0;
    step(3);
    rst = 1'b0;
    step(1);

    // Reset state
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_x_out", x_out, 0);
    chk("rst_w_out", w_out, 0);
    chk("rst_vals", 32'({x_out_val, w_out_val}), 0);
    chk("rst_flags", 32'({overflow, underflow}), 0);
    chk("rst_x_empty", 32'(x_empty), 32'hF);
    chk("rst_w_empty", 32'(w_empty), 32'hF);
    chk("rst_full", 32'({x_full, w_full}), 0);

    // 1: two words per lane, len=2; stray start mid-stream must be ignored
    for (int i = 0; i < SIZE; i++)
      for (int k = 0; k < 2; k++)
        load(1, i, 16 * (i + 1) + k, 1, i, 16 * (i + 1) + k + 128);
    do_start(2, t);
    for (int i = 0; i < SIZE; i++)
      for (int k = 0; k < 2; k++) begin
        ex(0, i, t + 2 + k + i, 16 * (i + 1) + k);
        ex(1, i, t + 2 + k + i, 16 * (i + 1) + k + 128);
      end
    dq.push_back(t + 7);
    start = 1'b1; stream_len = LBITS'(2);
    step(1);
    start = 1'b0;
    step(8);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_x_empty", 32'(x_empty), 32'hF);
    chk("t1_w_empty", 32'(w_empty), 32'hF);
    chk("t1_flags", 32'({overflow, underflow}), 0);

    // 2: overfill x lane 1
    for (int k = 0; k < 5; k++) load(1, 1, 8'hA0 + k, 0, 0, 0);
    chk("t2_overflow", 32'(overflow), 1);
    chk("t2_x_full", 32'(x_full), 32'b0010);
    pulse_err_clr();
    chk("t2_overflow_clr", 32'(overflow), 0);
    chk("t2_x_full_kept", 32'(x_full), 32'b0010);

    // 4: fill all lanes, push into full x lane 0 during the first pop
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < SIZE; i++)
        load(i != 1, i, 8'h50 + 16 * i + k, 1, i, 8'hC0 + 8 * i + k);
    do_start(4, t);
    for (int i = 0; i < SIZE; i++)
      for (int k = 0; k < 4; k++) begin
        ex(0, i, t + 2 + k + i, (i == 1) ? 8'hA0 + k : 8'h50 + 16 * i + k);
        ex(1, i, t + 2 + k + i, 8'hC0 + 8 * i + k);
      end
    dq.push_back(t + 9);
    load(1, 0, 8'h5F, 0, 0, 0);
    chk("t4_x_full", 32'(x_full), 32'b0001);
    chk("t4_overflow", 32'(overflow), 0);
    step(10);
    chk("t4_x_empty", 32'(x_empty), 32'b1110);
    chk("t4_w_empty", 32'(w_empty), 32'hF);
    chk("t4_flags", 32'({overflow, underflow}), 0);

    // 3: lane 2 empty on both sides, len=1; lane 0 still holds 0x5F
    load(1, 1, 8'h61, 1, 0, 8'hE0);
    load(1, 3, 8'h63, 1, 1, 8'hE1);
    load(0, 0, 0, 1, 3, 8'hE3);
    do_start(1, t);
    ex(0, 0, t + 2, 8'h5F); ex(0, 1, t + 3, 8'h61); ex(0, 3, t + 5, 8'h63);
    ex(1, 0, t + 2, 8'hE0); ex(1, 1, t + 3, 8'hE1); ex(1, 3, t + 5, 8'hE3);
    dq.push_back(t + 6);
    step(6);
    chk("t3_underflow", 32'(underflow), 1);
    chk("t3_overflow", 32'(overflow), 0);
    chk("t3_empty", 32'({x_empty, w_empty}), 32'hFF);
    pulse_err_clr();
    chk("t3_underflow_clr", 32'(underflow), 0);

    // 5: zero-length stream
    do_start(0, t);
    dq.push_back(t + 1);
    chk("t5_busy_hi", 32'(busy), 1);
    step(1);
    chk("t5_busy_lo", 32'(busy), 0);
    chk("t5_no_pop", 32'(underflow), 0);

    // 6: reset in the middle of a len=3 stream
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < SIZE; i++)
        load(1, i, 8'h20 + 16 * i + k, 1, i, 8'hB0 + 4 * i + k);
    load(1, 3, 8'hEE, 0, 0, 0);
    load(1, 3, 8'hEF, 0, 0, 0);
    chk("t6_overflow_pre", 32'(overflow), 1);
    do_start(3, t);
    ex(0, 0, t + 2, 8'h20);
    ex(1, 0, t + 2, 8'hB0);
    step(2);
    rst = 1'b1;
    #1;
    chk("t6_outs", 32'(x_out | w_out), 0);
    chk("t6_vals", 32'({x_out_val, w_out_val}), 0);
    chk("t6_flags", 32'({overflow, underflow}), 0);
    chk("t6_ctrl", 32'({busy, done}), 0);
    chk("t6_empty", 32'({x_empty, w_empty}), 32'hFF);
    chk("t6_full", 32'({x_full, w_full}), 0);
    step(1);
    rst = 1'b0;
    for (int i = 0; i < SIZE; i++) load(1, i, 8'h30 + i, 1, i, 8'h40 + i);
    do_start(1, t);
    for (int i = 0; i < SIZE; i++) begin
      ex(0, i, t + 2 + i, 8'h30 + i);
      ex(1, i, t + 2 + i, 8'h40 + i);
    end
    dq.push_back(t + 6);
    step(8);
    chk("t6b_empty", 32'({x_empty, w_empty}), 32'hFF);
    chk("t6b_flags", 32'({overflow, underflow}), 0);
    chk("t6b_busy", 32'(busy), 0);

    // Every expected output must have appeared within its cycle budget
    for (int i = 0; i < SIZE; i++) begin
      chk($sformatf("x%0d_pending", i), 32'(xq[i].size()), 0);
      chk($sformatf("w%0d_pending", i), 32'(wq[i].size()), 0);
    end
    chk("done_pending", 32'(dq.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
